// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sequencer: widths, opcodes, FSM states
// and opcode classification helpers.
package alu_pkg;

  localparam int DATA_W = 16;
  localparam int REG_AW = 4;
  localparam int OP_W   = 5;
  localparam int FLAG_W = 5;

  localparam logic [OP_W-1:0] OP_ADD  = 5'd0;
  localparam logic [OP_W-1:0] OP_SUB  = 5'd1;
  localparam logic [OP_W-1:0] OP_CMP  = 5'd2;
  localparam logic [OP_W-1:0] OP_AND  = 5'd3;
  localparam logic [OP_W-1:0] OP_OR   = 5'd4;
  localparam logic [OP_W-1:0] OP_XOR  = 5'd5;
  localparam logic [OP_W-1:0] OP_NOT  = 5'd6;
  localparam logic [OP_W-1:0] OP_LSH  = 5'd7;
  localparam logic [OP_W-1:0] OP_RSH  = 5'd8;
  localparam logic [OP_W-1:0] OP_ARSH = 5'd9;
  localparam logic [OP_W-1:0] NOP_OP  = 5'b11111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_EXEC = 2'd2,
    ST_WB   = 2'd3
  } state_t;

  // Opcodes 0..9 are implemented by the ALU; everything above is illegal.
  function automatic logic is_valid_op(input logic [OP_W-1:0] op);
    return op <= OP_ARSH;
  endfunction

  // CMP only produces flags, so it is the one valid op without a writeback.
  function automatic logic writes_back(input logic [OP_W-1:0] op);
    return is_valid_op(op) && (op != OP_CMP);
  endfunction

endpackage

// File: rtl/alu_sequencer_if.sv
// Command channel from instruction decode into the ALU sequencer.
interface alu_sequencer_if;
  import alu_pkg::*;

  logic              cmd_valid;
  logic              cmd_ready;
  logic [OP_W-1:0]   cmd_op;
  logic [REG_AW-1:0] cmd_rdest;
  logic [REG_AW-1:0] cmd_rsrc;
  logic              cmd_imm_en;
  logic [DATA_W-1:0] cmd_imm;

  modport master (
    output cmd_valid, cmd_op, cmd_rdest, cmd_rsrc, cmd_imm_en, cmd_imm,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_rdest, cmd_rsrc, cmd_imm_en, cmd_imm,
    output cmd_ready
  );

endinterface

// File: rtl/alu_sequencer.sv
// Four-state controller: accept a command, read operands, run the external
// combinational ALU, then write back the result and update the status flags.
module alu_sequencer
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  alu_sequencer_if.slave    cmd,
  output logic [REG_AW-1:0] rf_raddr_a,
  output logic [REG_AW-1:0] rf_raddr_b,
  input  logic [DATA_W-1:0] rf_rdata_a,
  input  logic [DATA_W-1:0] rf_rdata_b,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic [DATA_W-1:0] alu_rdest,
  output logic [DATA_W-1:0] alu_rsrc,
  output logic [OP_W-1:0]   alu_opcode,
  input  logic [DATA_W-1:0] alu_out,
  input  logic [FLAG_W-1:0] alu_flags,
  output logic [FLAG_W-1:0] psr_flags,
  output logic              busy,
  output logic              done,
  output logic              err
);

  state_t            state, state_nxt;
  logic              ready;
  logic [OP_W-1:0]   op_q;
  logic [REG_AW-1:0] rdest_q;
  logic [REG_AW-1:0] rsrc_q;
  logic              imm_en_q;
  logic [DATA_W-1:0] imm_q;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic [DATA_W-1:0] result_q;
  logic [FLAG_W-1:0] flags_q;
  logic [FLAG_W-1:0] psr_q;

  // State register plus the per-state capture of command, operands and results.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      op_q     <= '0;
      rdest_q  <= '0;
      rsrc_q   <= '0;
      imm_en_q <= 1'b0;
      imm_q    <= '0;
      op_a     <= '0;
      op_b     <= '0;
      result_q <= '0;
      flags_q  <= '0;
      psr_q    <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        ST_IDLE: begin
          if (cmd.cmd_valid) begin
            op_q     <= cmd.cmd_op;
            rdest_q  <= cmd.cmd_rdest;
            rsrc_q   <= cmd.cmd_rsrc;
            imm_en_q <= cmd.cmd_imm_en;
            imm_q    <= cmd.cmd_imm;
          end
        end
        ST_READ: begin
          op_a <= rf_rdata_a;
          op_b <= imm_en_q ? imm_q : rf_rdata_b;
        end
        ST_EXEC: begin
          result_q <= alu_out;
          flags_q  <= alu_flags;
        end
        ST_WB: begin
          if (is_valid_op(op_q)) psr_q <= flags_q;
        end
        default: ;
      endcase
    end
  end

  // Next-state and all state-decoded outputs.
  // NOTE: every output gets a default before the case so no path leaves a
  // signal unassigned, which would infer a latch.
  always_comb begin
    state_nxt  = state;
    ready      = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    err        = 1'b0;
    rf_we      = 1'b0;
    alu_opcode = NOP_OP;
    alu_rdest  = '0;
    alu_rsrc   = '0;
    case (state)
      ST_IDLE: begin
        ready = 1'b1;
        busy  = 1'b0;
        if (cmd.cmd_valid) state_nxt = ST_READ;
      end
      ST_READ: state_nxt = ST_EXEC;
      ST_EXEC: begin
        alu_rdest  = op_a;
        alu_rsrc   = op_b;
        alu_opcode = is_valid_op(op_q) ? op_q : NOP_OP;
        state_nxt  = ST_WB;
      end
      ST_WB: begin
        done      = 1'b1;
        rf_we     = writes_back(op_q);
        err       = !is_valid_op(op_q);
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign cmd.cmd_ready = ready;
  assign rf_raddr_a    = rdest_q;
  assign rf_raddr_b    = rsrc_q;
  assign rf_waddr      = rdest_q;
  assign rf_wdata      = result_q;
  assign psr_flags     = psr_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer with a behavioural register file and ALU.
// ALU flag layout used by the model: {lt_signed, overflow, negative, zero, carry}.
module tb_alu_sequencer;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_sequencer_if cmd_bus();

  logic [REG_AW-1:0] rf_raddr_a, rf_raddr_b, rf_waddr;
  logic [DATA_W-1:0] rf_rdata_a, rf_rdata_b, rf_wdata;
  logic              rf_we;
  logic [DATA_W-1:0] alu_rdest, alu_rsrc, alu_out;
  logic [OP_W-1:0]   alu_opcode;
  logic [FLAG_W-1:0] alu_flags, psr_flags;
  logic              busy, done, err;

  alu_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd        (cmd_bus),
    .rf_raddr_a (rf_raddr_a),
    .rf_raddr_b (rf_raddr_b),
    .rf_rdata_a (rf_rdata_a),
    .rf_rdata_b (rf_rdata_b),
    .rf_we      (rf_we),
    .rf_waddr   (rf_waddr),
    .rf_wdata   (rf_wdata),
    .alu_rdest  (alu_rdest),
    .alu_rsrc   (alu_rsrc),
    .alu_opcode (alu_opcode),
    .alu_out    (alu_out),
    .alu_flags  (alu_flags),
    .psr_flags  (psr_flags),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  // ---------------- behavioural register file ----------------
  logic [DATA_W-1:0] regs [16];
  bit preload_req = 1'b0;
  bit force_b     = 1'b0;

  assign rf_rdata_a = regs[rf_raddr_a];
  assign rf_rdata_b = force_b ? 16'hFFFF : regs[rf_raddr_b];

  always @(posedge clk) begin
    if (preload_req) begin
      for (int i = 0; i < 16; i++) regs[i] <= '0;
      regs[1] <= 16'd5;
      regs[2] <= 16'd3;
    end else if (rf_we) begin
      regs[rf_waddr] <= rf_wdata;
    end
  end

  // ---------------- behavioural ALU ----------------
  function automatic logic [20:0] alu_model(input logic [4:0] op,
                                            input logic [15:0] a, b);
    logic [16:0] s;
    logic [15:0] r;
    logic c, v;
    s = '0; r = '0; c = 1'b0; v = 1'b0;
    case (op)
      OP_ADD: begin
        s = {1'b0, a} + {1'b0, b};
        r = s[15:0];
        c = s[16];
        v = (a[15] == b[15]) && (r[15] != a[15]);
      end
      OP_SUB, OP_CMP: begin
        r = a - b;
        c = (a < b);
        v = (a[15] != b[15]) && (r[15] != a[15]);
      end
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_NOT:  r = ~a;
      OP_LSH:  r = a << b[3:0];
      OP_RSH:  r = a >> b[3:0];
      OP_ARSH: r = $unsigned($signed(a) >>> b[3:0]);
      default: return 21'd0;
    endcase
    return {($signed(a) < $signed(b)), v, r[15], (r == 16'd0), c, r};
  endfunction

  assign {alu_flags, alu_out} = alu_model(alu_opcode, alu_rdest, alu_rsrc);

  // ---------------- scoreboard ----------------
  typedef struct {
    int          acc;
    logic [4:0]  alu_op;
    logic [15:0] a;
    logic [15:0] b;
    logic        we;
    logic [3:0]  waddr;
    logic [15:0] wdata;
    logic        err;
    logic [4:0]  psr;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  bit   psr_pending = 1'b0;
  bit   watch_nop = 1'b0;
  logic [4:0] psr_exp_next;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input logic [4:0] alu_op, input logic [15:0] a, b,
                              input logic we, input logic [3:0] waddr,
                              input logic [15:0] wdata, input logic e,
                              input logic [4:0] psr);
    exp_t x;
    x.acc = 0; x.alu_op = alu_op; x.a = a; x.b = b; x.we = we;
    x.waddr = waddr; x.wdata = wdata; x.err = e; x.psr = psr;
    return x;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compares ALU drive in EXEC, writeback in WB and flags one cycle later.
  always @(negedge clk) begin
    if (!rst_n) begin
      psr_pending = 1'b0;
    end else begin
      if (psr_pending) begin
        check("psr_after_wb", psr_flags, psr_exp_next);
        check("ready_cycle4", cmd_bus.cmd_ready, 1);
        psr_pending = 1'b0;
      end
      if (rf_we && !done) check("we_outside_wb", rf_we, 0);
      if (watch_nop) check("nop_opcode", alu_opcode, NOP_OP);
      if (sb.size() > 0 && cyc == sb[0].acc + 2) begin
        check("exec_opcode", alu_opcode, sb[0].alu_op);
        check("exec_rdest", alu_rdest, sb[0].a);
        check("exec_rsrc", alu_rsrc, sb[0].b);
      end
      if (done) begin
        if (sb.size() == 0) begin
          check("unexpected_done", done, 0);
        end else begin
          mon_e = sb.pop_front();
          check("done_latency", cyc - mon_e.acc, 3);
          check("wb_we", rf_we, mon_e.we);
          check("wb_err", err, mon_e.err);
          if (mon_e.we) begin
            check("wb_waddr", rf_waddr, mon_e.waddr);
            check("wb_wdata", rf_wdata, mon_e.wdata);
          end
          psr_exp_next = mon_e.psr;
          psr_pending  = 1'b1;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic preload();
    @(negedge clk);
    preload_req = 1'b1;
    @(posedge clk);
    #1 preload_req = 1'b0;
    @(negedge clk);
  endtask

  // Called just after a negedge; returns at the negedge of cycle 1.
  task automatic issue(input logic [4:0] op, input logic [3:0] rd, rs,
                       input logic ie, input logic [15:0] imm, input exp_t e,
                       input bit keep, output int acc, output int waits);
    cmd_bus.cmd_op     = op;
    cmd_bus.cmd_rdest  = rd;
    cmd_bus.cmd_rsrc   = rs;
    cmd_bus.cmd_imm_en = ie;
    cmd_bus.cmd_imm    = imm;
    cmd_bus.cmd_valid  = 1'b1;
    waits = 0;
    acc = 0;
    while (!cmd_bus.cmd_ready && waits < 20) begin
      @(negedge clk);
      waits++;
    end
    if (!cmd_bus.cmd_ready) begin
      check("accept_timeout", 0, 1);
      cmd_bus.cmd_valid = 1'b0;
      return;
    end
    acc = cyc;
    e.acc = cyc;
    sb.push_back(e);
    @(negedge clk);
    if (!keep) cmd_bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((sb.size() != 0 || psr_pending) && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0 || psr_pending) check("drain_timeout", 0, 1);
    @(negedge clk);
  endtask

  initial begin
    int acc1, acc2, w;
    cmd_bus.cmd_valid  = 1'b0;
    cmd_bus.cmd_op     = '0;
    cmd_bus.cmd_rdest  = '0;
    cmd_bus.cmd_rsrc   = '0;
    cmd_bus.cmd_imm_en = 1'b0;
    cmd_bus.cmd_imm    = '0;

    preload();
    check("rst_ready", cmd_bus.cmd_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_we", rf_we, 0);
    check("rst_psr", psr_flags, 0);
    check("rst_opcode", alu_opcode, NOP_OP);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: ADD R1,R2 -> 8
    preload();
    issue(OP_ADD, 4'd1, 4'd2, 1'b0, 16'h0, mk(OP_ADD, 16'd5, 16'd3, 1, 4'd1, 16'd8, 0, 5'b00000), 0, acc1, w);
    wait_idle();
    check("t1_r1", regs[1], 16'd8);

    // 2: CMP R1,R2 -> no writeback, R1 stays 5
    preload();
    issue(OP_CMP, 4'd1, 4'd2, 1'b0, 16'h0, mk(OP_CMP, 16'd5, 16'd3, 0, 4'd1, 16'd0, 0, 5'b00000), 0, acc1, w);
    wait_idle();
    check("t2_r1", regs[1], 16'd5);

    // 3: SUB R1,#1 with port b forced to FFFF -> 4
    preload();
    force_b = 1'b1;
    issue(OP_SUB, 4'd1, 4'd2, 1'b1, 16'h0001, mk(OP_SUB, 16'd5, 16'd1, 1, 4'd1, 16'd4, 0, 5'b00000), 0, acc1, w);
    wait_idle();
    force_b = 1'b0;
    check("t3_r1", regs[1], 16'd4);

    // 5: back-to-back ADD then XOR with cmd_valid held high
    preload();
    issue(OP_ADD, 4'd1, 4'd2, 1'b0, 16'h0, mk(OP_ADD, 16'd5, 16'd3, 1, 4'd1, 16'd8, 0, 5'b00000), 1, acc1, w);
    issue(OP_XOR, 4'd1, 4'd2, 1'b0, 16'h0, mk(OP_XOR, 16'd8, 16'd3, 1, 4'd1, 16'd11, 0, 5'b00000), 0, acc2, w);
    check("t5_busy_waits", w, 3);
    check("t5_accept_gap", acc2 - acc1, 4);
    wait_idle();
    check("t5_r1", regs[1], 16'd11);

    // CMP R2,R1: 3-5 sets carry, negative and signed-less-than
    preload();
    issue(OP_CMP, 4'd2, 4'd1, 1'b0, 16'h0, mk(OP_CMP, 16'd3, 16'd5, 0, 4'd2, 16'd0, 0, 5'b10101), 0, acc1, w);
    wait_idle();

    // 4: invalid opcode -> err, no write, flags retained, ALU sees NOP throughout
    @(negedge clk);
    watch_nop = 1'b1;
    issue(5'b01010, 4'd1, 4'd2, 1'b0, 16'h0, mk(NOP_OP, 16'd5, 16'd3, 0, 4'd1, 16'd0, 1, 5'b10101), 0, acc1, w);
    wait_idle();
    watch_nop = 1'b0;
    check("t4_r1", regs[1], 16'd5);

    // 6: reset during EXEC aborts the command
    issue(OP_ADD, 4'd1, 4'd2, 1'b0, 16'h0, mk(OP_ADD, 16'd5, 16'd3, 1, 4'd1, 16'd8, 0, 5'b00000), 0, acc1, w);
    @(posedge clk);
    #1 rst_n = 1'b0;
    sb.delete();
    #1;
    check("t6_we", rf_we, 0);
    check("t6_done", done, 0);
    check("t6_busy", busy, 0);
    check("t6_ready", cmd_bus.cmd_ready, 1);
    check("t6_opcode", alu_opcode, NOP_OP);
    check("t6_psr", psr_flags, 0);
    repeat (3) @(negedge clk);
    check("t6_r1_kept", regs[1], 16'd5);
    rst_n = 1'b1;
    @(negedge clk);
    check("t6_ready_after", cmd_bus.cmd_ready, 1);
    issue(OP_ADD, 4'd1, 4'd2, 1'b0, 16'h0, mk(OP_ADD, 16'd5, 16'd3, 1, 4'd1, 16'd8, 0, 5'b00000), 0, acc1, w);
    wait_idle();
    check("t6_r1", regs[1], 16'd8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
